// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- sequencing controller for the shared multiply/divide unit (EX).
//
// Accepts mult/multu/div/divu/mthi/mtlo and owns the HI/LO registers. For a
// multiply or divide, the result is computed when the instruction is accepted
// and held as "pending". A down-counter then runs out the fixed latency, and
// the pending value is written to HI/LO on the edge where busy falls.
//
// Ports:
//   clk      in   1   clock, all state on rising edge
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   EX-stage MD instruction valid this cycle
//   op       in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   rs_val   in  32   forwarded rs operand
//   rt_val   in  32   forwarded rt operand
//   cancel   in   1   EX flush; kills a same-cycle start only
//   busy     out  1   registered; high while a mult/div is in flight
//   hi       out 32   HI register
//   lo       out 32   LO register
// ---------------------------------------------------------------------------
module md_sched #(
    parameter int MULT_CYCLES = 5,   // legal range 1..15
    parameter int DIV_CYCLES  = 10   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        r_state;
    logic [3:0]  r_count;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;   // low for divide-by-zero: completion leaves HI/LO alone

    logic        w_acc;
    logic        w_signed_div;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_rt_div;
    logic        w_div_zero;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;

    // Only IDLE accepts; a start while RUN cannot legally happen and is ignored.
    assign w_acc = start & ~cancel & (r_state == ST_IDLE);

    // Multiplies: the low 64 bits of a product of sign-extended operands
    // equal the signed product, so one 64-bit multiplier form covers both.
    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divides: a signed divide is done on magnitudes and the signs are
    // reapplied. This also gives 0x80000000 / -1 = 0x80000000 rem 0 without
    // any special case, because |0x80000000| is still 0x80000000 unsigned.
    assign w_signed_div = (op == OP_DIV);
    assign w_rs_neg     = w_signed_div & rs_val[31];
    assign w_rt_neg     = w_signed_div & rt_val[31];
    assign w_rs_mag     = w_rs_neg ? (32'd0 - rs_val) : rs_val;
    assign w_rt_mag     = w_rt_neg ? (32'd0 - rt_val) : rt_val;
    assign w_div_zero   = (rt_val == 32'd0);
    // Substitute a divisor of 1 so the divider never sees zero; the result is
    // discarded anyway through r_pend_wr.
    assign w_rt_div     = w_div_zero ? 32'd1 : w_rt_mag;
    assign w_uquot      = w_rs_mag / w_rt_div;
    assign w_urem       = w_rs_mag % w_rt_div;
    assign w_quot       = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_uquot) : w_uquot;
    assign w_rem        = w_rs_neg ? (32'd0 - w_urem) : w_urem;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        w_res_wr = 1'b1;
        case (op)
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
                w_res_wr = ~w_div_zero;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_pend_wr <= w_res_wr;
                                r_count   <= (op == OP_MULT || op == OP_MULTU)
                                             ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= ST_RUN;
                            end
                            OP_MTHI: r_hi <= rs_val;
                            OP_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // cancel is deliberately ignored here: the in-flight
                    // instruction is older than the flush and has committed.
                    if (r_count == 4'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= 4'd0;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// ---------------------------------------------------------------------------
// tb_md_sched -- self-checking bench for md_sched.
// Stimulus pushes the expected completion {hi, lo, busy length} into a queue.
// A monitor process, sampling on the falling clock edge, measures each busy
// pulse and pops and compares an entry when busy falls.
// ---------------------------------------------------------------------------
module tb_md_sched;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .cancel  (cancel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles at each falling edge; on busy falling it
    // pops the oldest expectation and compares the completion.
    initial begin : monitor
        int   cnt;
        logic prev;
        exp_t e;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cnt  = 0;
                prev = 1'b0;
            end else if (busy) begin
                cnt++;
                prev = 1'b1;
            end else begin
                if (prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_busy_len", 32'(cnt), 32'(e.cycles));
                        check("done_hi", hi, e.hi);
                        check("done_lo", lo, e.lo);
                    end
                end
                cnt  = 0;
                prev = 1'b0;
            end
        end
    end

    // Present one instruction for exactly one clock edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        @(posedge clk);
        #1;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        cancel = c;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    // Bounded wait for busy to be low at a falling edge.
    task automatic wait_idle(input string name);
        bool_wait: begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!busy) disable bool_wait;
            end
            check(name, 32'(busy), 32'd0);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi     = h;
        e.lo     = l;
        e.cycles = n;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        rs_val  = 32'd0;
        rt_val  = 32'd0;
        cancel  = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        #2 reset_n = 1'b1;

        // mult -2 * 3; hi/lo must hold 0/0 while busy
        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        @(negedge clk);
        check("mult_hold_busy", 32'(busy), 32'd1);
        check("mult_hold_hi", hi, 32'd0);
        check("mult_hold_lo", lo, 32'd0);
        wait_idle("mult_timeout");

        // multu max * max
        push(32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle("multu_timeout");

        // div -7 / 2 -> q=-3, r=-1
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle("div_neg_timeout");

        // divu 7 / 2
        push(32'd1, 32'd3, 10);
        issue(3'd3, 32'd7, 32'd2, 1'b0);
        wait_idle("divu_timeout");

        // signed overflow case
        push(32'd0, 32'h8000_0000, 10);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle("div_ovf_timeout");

        // mthi / mtlo set up prior values
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'h22);

        // divide by zero: full latency, hi/lo unchanged; mid-busy start ignored
        push(32'h11, 32'h22, 10);
        issue(3'd2, 32'd5, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        issue(3'd0, 32'd5, 32'd5, 1'b0);
        wait_idle("divz_timeout");
        repeat (12) @(negedge clk);
        check("divz_no_extra_busy", 32'(busy), 32'd0);
        check("divz_hi_after", hi, 32'h11);
        check("divz_lo_after", lo, 32'h22);

        // start + cancel: nothing happens
        issue(3'd0, 32'd9, 32'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cancel_busy", 32'(busy), 32'd0);
        end
        repeat (5) @(negedge clk);
        check("cancel_hi", hi, 32'h11);
        check("cancel_lo", lo, 32'h22);

        // mtlo 0xABCD
        issue(3'd5, 32'hABCD, 32'd0, 1'b0);
        @(negedge clk);
        check("mtlo2_lo", lo, 32'hABCD);
        check("mtlo2_hi", hi, 32'h11);
        check("mtlo2_busy", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a div: no completion afterwards
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("arst_after_busy", 32'(busy), 32'd0);
        check("arst_after_hi", hi, 32'd0);
        check("arst_after_lo", lo, 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
